// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with a one-cycle register-file writeback.
// Define MULDIV_DIV_EN to build the restoring divider; without it ops 4-7 retire at once with no write.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            wr_en_o,
  output logic [4:0]      wrd_o,
  output logic [XLEN-1:0] wdata_o
);

  localparam int unsigned PW = 2 * XLEN;
  localparam int unsigned CW = 5;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
`ifdef MULDIV_DIV_EN
  logic [XLEN-1:0] b_q, b_d;
  logic            rneg_q, rneg_d;
  logic            div0_q, div0_d;
`endif
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            wr_en_q, wr_en_d;
  logic [4:0]      wrd_q, wrd_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  logic            s1_sgn, s2_sgn, neg1, neg2;
  logic [XLEN-1:0] abs1, abs2;
  logic [XLEN:0]   mul_sum;
  logic [PW-1:0]   mul_step, prod_neg;
  logic [XLEN-1:0] mulh_res, fix_res;
`ifdef MULDIV_DIV_EN
  logic [XLEN:0]   div_sh, div_diff;
  logic [PW-1:0]   div_step;
  logic [XLEN-1:0] quo_res, rem_res;
`endif

  // Operand magnitudes and sign flags captured on accept
  always_comb begin
    s1_sgn = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
    s2_sgn = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    neg1   = s1_sgn & rs1_i[XLEN-1];
    neg2   = s2_sgn & rs2_i[XLEN-1];
    abs1   = neg1 ? (XLEN'(0) - rs1_i) : rs1_i;
    abs2   = neg2 ? (XLEN'(0) - rs2_i) : rs2_i;
  end

  // Iteration steps and result selection; low half of prod holds multiplier / dividend bits
  always_comb begin
    mul_sum  = {1'b0, prod_q[PW-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
    mul_step = {mul_sum, prod_q[XLEN-1:1]};
    prod_neg = PW'(0) - prod_q;
    mulh_res = neg_q ? prod_neg[PW-1:XLEN] : prod_q[PW-1:XLEN];
`ifdef MULDIV_DIV_EN
    div_sh   = {prod_q[PW-1:XLEN], prod_q[XLEN-1]};
    div_diff = div_sh - {1'b0, b_q};
    // partial remainder stays below 2^32, so the top diff bit is exactly the borrow
    div_step = div_diff[XLEN] ? {div_sh[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    quo_res  = div0_q ? {XLEN{1'b1}}
                      : (neg_q ? (XLEN'(0) - prod_q[XLEN-1:0]) : prod_q[XLEN-1:0]);
    rem_res  = rneg_q ? (XLEN'(0) - prod_q[PW-1:XLEN]) : prod_q[PW-1:XLEN];
`endif
    fix_res = '0;
    case (op_q)
      OP_MUL:                       fix_res = prod_q[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = mulh_res;
`ifdef MULDIV_DIV_EN
      OP_DIV, OP_DIVU:              fix_res = quo_res;
      OP_REM, OP_REMU:              fix_res = rem_res;
`else
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: fix_res = '0;
`endif
      default:                      fix_res = '0;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    a_d     = a_q;
    op_d    = op_q;
    neg_d   = neg_q;
`ifdef MULDIV_DIV_EN
    b_d     = b_q;
    rneg_d  = rneg_q;
    div0_d  = div0_q;
`endif
    busy_d  = busy_q;
    done_d  = 1'b0;
    wr_en_d = 1'b0;
    wrd_d   = wrd_q;
    wdata_d = '0;

    case (state_q)
      S_CALC: begin
        cnt_d = cnt_q + CW'(1);
`ifdef MULDIV_DIV_EN
        prod_d = op_q[2] ? div_step : mul_step;
`else
        prod_d = mul_step;
`endif
        if (cnt_q == CW'(XLEN - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        wr_en_d = (wrd_q != 5'd0);
        wdata_d = fix_res;
      end
      S_DONE:  state_d = S_IDLE;
      default: ;
    endcase

    // flush beats everything outside IDLE; in IDLE a start is taken regardless of flush
    if (flush_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      wr_en_d = 1'b0;
      wdata_d = '0;
    end else if (start_i && !busy_q) begin
      op_d   = op_i;
      wrd_d  = rd_i;
      a_d    = abs1;
      neg_d  = neg1 ^ neg2;
      cnt_d  = '0;
      prod_d = {XLEN'(0), (op_i[2] ? abs1 : abs2)};
`ifdef MULDIV_DIV_EN
      b_d     = abs2;
      rneg_d  = neg1;
      div0_d  = (rs2_i == '0);
      state_d = S_CALC;
      busy_d  = 1'b1;
`else
      if (op_i[2]) begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d = S_CALC;
        busy_d  = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      a_q     <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
      b_q     <= '0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
`endif
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      wrd_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      a_q     <= a_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
`ifdef MULDIV_DIV_EN
      b_q     <= b_d;
      rneg_q  <= rneg_d;
      div0_q  <= div0_d;
`endif
      busy_q  <= busy_d;
      done_q  <= done_d;
      wr_en_q <= wr_en_d;
      wrd_q   <= wrd_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign wr_en_o = wr_en_q;
  assign wrd_o   = wrd_q;
  assign wdata_o = wdata_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model checked every cycle plus directed literal vectors.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, flush_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i, rs2_i;
  logic [4:0]  rd_i;
  logic        busy_o, done_o, wr_en_o;
  logic [4:0]  wrd_o;
  logic [31:0] wdata_o;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  muldiv_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .op_i    (op_i),
    .rs1_i   (rs1_i),
    .rs2_i   (rs2_i),
    .rd_i    (rd_i),
    .flush_i (flush_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .wr_en_o (wr_en_o),
    .wrd_o   (wrd_o),
    .wdata_o (wdata_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, required %h", name, $time, act, exp);
    end
  endtask

  // RV32M results from plain integer arithmetic
  function automatic logic [31:0] golden(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    logic [31:0] r;
    sa = int'(a);
    sb = int'(b);
    r  = '0;
    case (op)
      3'd0: begin up = 64'(a) * 64'(b); r = up[31:0]; end
      3'd1: begin sp = longint'(sa) * longint'(sb); r = sp[63:32]; end
      3'd2: begin sp = longint'(sa) * longint'(64'(b)); r = sp[63:32]; end
      3'd3: begin up = 64'(a) * 64'(b); r = up[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF :
                (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a :
                (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Transaction-level model: one op outstanding, done at a fixed edge after accept
  bit          m_active = 1'b0;
  int          edge_n   = 0;
  int          m_done   = 0;
  logic [31:0] m_res    = '0;
  logic [4:0]  m_rd     = '0;
  bit          m_we     = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
    end else begin
      bit nonidle, mbusy;
      edge_n++;
      nonidle = m_active && (edge_n - 1 <= m_done);
      mbusy   = m_active && (edge_n - 1 < m_done);
      if (flush_i && nonidle) begin
        m_active = 1'b0;
      end else if (start_i && !mbusy) begin
        m_active = 1'b1;
        m_rd     = rd_i;
        if (op_i[2] && !DIV_EN) begin
          m_done = edge_n;
          m_res  = '0;
          m_we   = 1'b0;
        end else begin
          m_done = edge_n + 33;
          m_res  = golden(op_i, rs1_i, rs2_i);
          m_we   = (rd_i != 5'd0);
        end
      end
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_wr_en", 32'(wr_en_o), 32'd0);
      check("rst_wrd", 32'(wrd_o), 32'd0);
      check("rst_wdata", wdata_o, 32'd0);
    end else begin
      bit exp_done, exp_busy;
      exp_done = m_active && (edge_n == m_done);
      exp_busy = m_active && (edge_n < m_done);
      check("cyc_busy", 32'(busy_o), 32'(exp_busy));
      check("cyc_done", 32'(done_o), 32'(exp_done));
      check("cyc_wr_en", 32'(wr_en_o), 32'(exp_done && m_we));
      check("cyc_wdata", wdata_o, exp_done ? m_res : 32'd0);
      if (exp_done) check("cyc_wrd", 32'(wrd_o), 32'(m_rd));
    end
  end

  // Issue one op, wait (bounded) for done_o, check literal result and latency
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_w, input logic exp_we,
                       input int exp_lat, input bit fl, input int pulse_at, input string name);
    int lat;
    start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_i = rd; flush_i = fl;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    op_i = 3'($urandom); rs1_i = $urandom; rs2_i = $urandom; rd_i = 5'($urandom);
    lat = 0;
    while (done_o !== 1'b1 && lat < 60) begin
      start_i = (lat == pulse_at);
      @(posedge clk); #1;
      lat++;
    end
    start_i = 1'b0;
    if (done_o !== 1'b1) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: no done_o within 60 cycles, required one", name);
    end else begin
      check({name, "_lat"}, 32'(lat + 1), 32'(exp_lat));
      check({name, "_wdata"}, wdata_o, exp_w);
      check({name, "_wr_en"}, 32'(wr_en_o), 32'(exp_we));
      check({name, "_wrd"}, 32'(wrd_o), 32'(rd));
      check({name, "_busy"}, 32'(busy_o), 32'd0);
    end
  endtask

  task automatic expect_quiet(input int cycles, input string name);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) seen++;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    op_i = '0; rs1_i = '0; rs2_i = '0; rd_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // multiply, issued back to back
    do_op(3'd0, 32'd7, 32'd6, 5'd5, 32'd42, 1'b1, 34, 1'b0, -1, "mul_7x6");
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0, 1'b1, 34, 1'b0, -1, "mulh_m1m1");
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'hFFFF_FFFE, 1'b1, 34, 1'b0, -1, "mulhu_max");
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd10, 32'hFFFF_FFFF, 1'b1, 34, 1'b0, -1, "mulhsu_m1x2");
    do_op(3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1'b1, 34, 1'b0, -1, "mul_min");
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd12, 32'h4000_0000, 1'b1, 34, 1'b0, -1, "mulh_minmin");
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1'b1, 34, 1'b0, -1, "mulhsu_min");
    do_op(3'd1, 32'd3, 32'hFFFF_FFFE, 5'd14, 32'hFFFF_FFFF, 1'b1, 34, 1'b0, -1, "mulh_3xm2");

`ifdef MULDIV_DIV_EN
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd15, 32'hFFFF_FFFD, 1'b1, 34, 1'b0, -1, "div_m7_2");
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd16, 32'hFFFF_FFFF, 1'b1, 34, 1'b0, -1, "rem_m7_2");
    do_op(3'd5, 32'd100, 32'd0, 5'd17, 32'hFFFF_FFFF, 1'b1, 34, 1'b0, -1, "divu_by0");
    do_op(3'd7, 32'd100, 32'd0, 5'd18, 32'd100, 1'b1, 34, 1'b0, -1, "remu_by0");
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h8000_0000, 1'b1, 34, 1'b0, -1, "div_ovf");
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h0, 1'b1, 34, 1'b0, -1, "rem_ovf");
    do_op(3'd4, 32'hFFFF_FFF9, 32'd0, 5'd21, 32'hFFFF_FFFF, 1'b1, 34, 1'b0, -1, "div_m7_by0");
    do_op(3'd6, 32'hFFFF_FFF9, 32'd0, 5'd22, 32'hFFFF_FFF9, 1'b1, 34, 1'b0, -1, "rem_m7_by0");
    do_op(3'd5, 32'd100, 32'd7, 5'd23, 32'd14, 1'b1, 34, 1'b0, -1, "divu_100_7");
    do_op(3'd7, 32'd100, 32'd7, 5'd24, 32'd2, 1'b1, 34, 1'b0, -1, "remu_100_7");
    do_op(3'd6, 32'd7, 32'hFFFF_FFFE, 5'd25, 32'd1, 1'b1, 34, 1'b0, -1, "rem_7_m2");
`else
    do_op(3'd4, 32'd10, 32'd2, 5'd15, 32'h0, 1'b0, 1, 1'b0, -1, "nodiv_div");
    do_op(3'd7, 32'd100, 32'd7, 5'd16, 32'h0, 1'b0, 1, 1'b0, -1, "nodiv_remu");
`endif
    do_op(3'd0, 32'd5, 32'd5, 5'd26, 32'd25, 1'b1, 34, 1'b0, -1, "mul_5x5");

    // rd=0 completes without a write; a start pulse while busy is ignored
    do_op(3'd0, 32'd3, 32'd3, 5'd0, 32'd9, 1'b0, 34, 1'b0, 9, "mul_rd0");
    expect_quiet(40, "rd0_no_second_done");

    // flush mid-calculation
    start_i = 1'b1; op_i = 3'd0; rs1_i = 32'd9; rs2_i = 32'd9; rd_i = 5'd4;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("flush_busy_before", 32'(busy_o), 32'd1);
    repeat (14) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush_busy_after", 32'(busy_o), 32'd0);
    expect_quiet(40, "flush_no_done");

    // flush alone in IDLE does nothing; with start in IDLE the start wins
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("idle_flush_busy", 32'(busy_o), 32'd0);
    do_op(3'd3, 32'd6, 32'd7, 5'd27, 32'd0, 1'b1, 34, 1'b1, -1, "start_flush_idle");
    @(posedge clk); #1;

    // asynchronous reset mid-operation
    start_i = 1'b1; op_i = 3'd0; rs1_i = 32'd11; rs2_i = 32'd13; rd_i = 5'd6;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_done", 32'(done_o), 32'd0);
    check("arst_wr_en", 32'(wr_en_o), 32'd0);
    check("arst_wrd", 32'(wrd_o), 32'd0);
    check("arst_wdata", wdata_o, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(3'd0, 32'd2, 32'd2, 5'd8, 32'd4, 1'b1, 34, 1'b0, -1, "mul_after_rst");
    expect_quiet(5, "tail_quiet");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit. It sits between the register-file read ports and the register-file write port. It latches rs1/rs2 operand values plus the destination index on a start handshake and computes the M-extension result over a fixed number of cycles. It then presents a single-cycle writeback (write enable, destination, data) that drives the register file's write port directly.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_i  input  1  request; accepted on a rising edge where start_i=1 and busy_o=0.
- op_i  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_i  input  32  operand A (dividend / multiplicand).
- rs2_i  input  32  operand B (divisor / multiplier).
- rd_i  input  5  destination register index.
- flush_i  input  1  abort any in-flight operation.
- busy_o  output  1  unit occupied; start_i ignored while high.
- done_o  output  1  one-cycle completion pulse.
- wr_en_o  output  1  register-file write enable; high only with done_o and only when wrd_o≠0.
- wrd_o  output  5  destination index (latched rd_i).
- wdata_o  output  32  result; valid while done_o=1, 0 otherwise.

## Operation
- FSM states:
  - IDLE: start accepted → CALC.
  - CALC: 32 iterations → FIX.
  - FIX: sign correction and special-case select → DONE.
  - DONE: → IDLE unconditionally.
- On accept, the unit latches the following, then ignores input changes until the next accept:
  - op_i and rd_i.
  - Absolute values of rs1_i/rs2_i according to signedness: MULH/DIV/REM signed both; MULHSU signed rs1 only; MULHU/DIVU/REMU/MUL unsigned.
  - Result sign flags.
- Multiply: radix-2 shift-add over a 64-bit product, one bit per CALC cycle.
  - MUL returns product[31:0].
  - MULH* return product[63:32] after two's-complement negation of the 64-bit value if the sign flag is set.
- Divide: restoring, one quotient bit per CALC cycle.
  - Quotient is negated if operand signs differ.
  - Remainder takes the dividend's sign.
- Special cases are resolved in FIX; iteration still runs, so latency is unchanged:
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- rd_i=0: operation completes normally with done_o=1, but wr_en_o stays 0.
- flush_i=1 in any state except IDLE:
  - Next state is IDLE with no done_o/wr_en_o pulse.
  - flush_i in IDLE has no effect.
  - flush_i and start_i asserted in the same IDLE cycle: start wins.
- Reset (asynchronous, any state):
  - FSM → IDLE.
  - busy_o, done_o, wr_en_o = 0; wrd_o = 0; wdata_o = 0.
  - Iteration counter and datapath registers = 0.

## Timing
- Accept edge N:
  - busy_o=1 from N.
  - CALC edges N+1..N+32.
  - FIX edge N+33.
  - DONE cycle between N+33 and N+34: done_o=1, wr_en_o per rd rule, busy_o=0.
- Latency: 34 cycles from accept to done_o, fixed for every op and operand value.
- Back-to-back: a new start_i may be accepted at edge N+34, i.e. during the DONE cycle. Throughput is one op per 34 cycles.
- done_o, wr_en_o, wrd_o, wdata_o are registered outputs; there is no combinational path from any input.
- 5-bit iteration counter counts 0..31 and wraps to 0 on CALC exit.

## Configuration
- MULDIV_DIV_EN defined: ops 4–7 are implemented as above.
- MULDIV_DIV_EN undefined:
  - Divider datapath is not compiled.
  - Ops 4–7 are still accepted. They skip CALC/FIX: IDLE → DONE in 1 edge, so done_o is high in the cycle after the accept edge.
  - wr_en_o=0 and wdata_o=0 for these ops.
  - Multiply ops are unchanged.

## Test plan
- MUL rs1=7, rs2=6, rd=5 → done_o exactly 34 cycles after accept; wr_en_o=1, wrd_o=5, wdata_o=42; busy_o low in the DONE cycle.
- MULH 0xFFFFFFFF×0xFFFFFFFF → 0; MULHU same operands → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/0 → 0xFFFFFFFF; REMU 100/0 → 100; DIV 0x80000000/−1 → 0x80000000; REM same → 0.
- rd=0 with MUL 3×3 → done_o=1, wr_en_o=0; start_i pulsed at accept+10 is ignored (no second done_o).
- flush_i at accept+15 → busy_o=0 next cycle, no done_o within 40 cycles. rst_n low at accept+20 → all outputs 0 immediately, then a new MUL 2×2 completes with 4.
- MULDIV_DIV_EN undefined: DIV 10/2 → done_o one cycle after accept, wr_en_o=0, wdata_o=0; MUL 5×5 still returns 25 at 34 cycles.
